// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults, FSM encoding and pixel packing for the camera capture path
package cam_pkg;
  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;
  localparam int DEF_AW = 15;
  typedef enum logic [1:0] {WAIT_VS, BLANK, ACTIVE} cam_state_t;
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: two-flop synchronizer plus history flop with level and edge outputs
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  // shift the asynchronous pin through the synchronizer and history stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {din, s1, s2};
  assign lvl = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/cam_capture_rgb.sv
// cam_capture_rgb: oversampled OV7670-style capture, RGB565 byte pairs to RGB332 frame-buffer writes
module cam_capture_rgb
  import cam_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          frame_err
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int PW = AW + 10;
  localparam logic [XW-1:0] X_END = XW'(IMG_W);
  localparam logic [YW-1:0] Y_END = YW'(IMG_H);
  localparam logic [AW-1:0] A_LAST = AW'(IMG_W * IMG_H - 1);
  cam_state_t state, state_nx;
  logic pc_rise, unused_pc_lvl, unused_pc_fall;
  logic hs_lvl, hs_rise, hs_fall, vs_lvl, vs_rise, vs_fall;
  logic [7:0] d1, d2, byte1, wr_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] addr, wr_a;
  logic phase, full, wr_v, dn_v, frm_start, frm_end, cap;
  logic px_ev, ph, wr_ok;
  logic [PW-1:0] pa, pb;
  cam_sync_edge u_pclk (
    .clk(clk), .rst(rst), .din(CAM_pclk),
    .lvl(unused_pc_lvl), .rise(pc_rise), .fall(unused_pc_fall)
  );
  cam_sync_edge u_href (
    .clk(clk), .rst(rst), .din(CAM_href),
    .lvl(hs_lvl), .rise(hs_rise), .fall(hs_fall)
  );
  cam_sync_edge u_vsync (
    .clk(clk), .rst(rst), .din(CAM_vsync),
    .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall)
  );
  // data takes the same two-stage path as the pclk synchronizer so bytes line up with the detected edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) {d1, d2} <= '0;
    else {d1, d2} <= {CAM_px_data, d1};
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= WAIT_VS;
    else state <= state_nx;
  // FSM next state: wait for blanking, then alternate blanking and active video on vsync edges
  always_comb
    state_nx = (state == WAIT_VS) ? (vs_lvl ? BLANK : WAIT_VS) :
               (state == BLANK)   ? (vs_fall ? ACTIVE : BLANK) :
                                    (vs_rise ? BLANK : ACTIVE);
  // FSM outputs: frame start/end events and the capture window
  always_comb begin
    frm_start = state == BLANK && vs_fall;
    frm_end = state == ACTIVE && vs_rise;
    cap = state == ACTIVE && !vs_rise;
  end
  assign px_ev = cap && hs_lvl && pc_rise;
  assign ph = phase & ~hs_rise;
  assign wr_ok = x != X_END && y != Y_END && !full;
  // byte assembly, line/frame counters and sticky error tracking
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {phase, full, frame_err, wr_v, dn_v} <= '0;
      {byte1, wr_d, wr_a, addr, x, y} <= '0;
    end else begin
      wr_v <= px_ev && ph && wr_ok;
      dn_v <= frm_end;
      if (frm_start) begin
        {phase, full, frame_err} <= '0;
        {addr, x, y} <= '0;
      end else if (px_ev) begin
        phase <= ~ph;
        if (!ph) byte1 <= d2;
        else begin
          wr_a <= addr;
          wr_d <= rgb565_to_332(byte1, d2);
          if (wr_ok) begin
            x <= x + 1'b1;
            full <= addr == A_LAST;
            addr <= addr == A_LAST ? addr : addr + 1'b1;
          end else frame_err <= 1'b1;
        end
      end else if (cap && hs_rise) phase <= 1'b0;
      else if (cap && hs_fall) begin
        phase <= 1'b0;
        x <= '0;
        if (phase || (x != '0 && x != X_END)) frame_err <= 1'b1;
        if (x != '0 && y != Y_END) y <= y + 1'b1;
      end
      if (frm_end && hs_lvl) frame_err <= 1'b1;
    end
  assign pa = {wr_v, wr_a, wr_d, dn_v};
  // two-stage output delay keeps writes and frame_done in order at the fixed latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pb <= '0;
      {mem_we, mem_addr, mem_data, frame_done} <= '0;
    end else begin
      pb <= pa;
      {mem_we, mem_addr, mem_data, frame_done} <= pb;
    end
endmodule

// File: tb/tb_cam_capture_rgb.sv
// tb_cam_capture_rgb: scoreboard bench driving camera frames into cam_capture_rgb
module tb_cam_capture_rgb;
  localparam int W = 16;
  localparam int H = 8;
  localparam int AW = 7;
  logic clk = 0, rst = 0, CAM_pclk = 0, CAM_vsync = 0, CAM_href = 0;
  logic [7:0] CAM_px_data = 0;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  logic mem_we, frame_done, frame_err;
  typedef struct {int a; int d; int c;} wr_t;
  wr_t wq[$];
  wr_t e;
  int dq[$];
  int checks = 0, errors = 0, cyc = 0;
  bit m_active = 0, m_armed = 0, m_full = 0, m_err = 0;
  int m_x = 0, m_y = 0, m_addr = 0;

  cam_capture_rgb #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .rst(rst), .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync),
    .CAM_href(CAM_href), .CAM_px_data(CAM_px_data), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  function automatic int exp332(input int hi, input int lo);
    return ((hi >> 5) << 5) | ((hi & 7) << 2) | ((lo >> 3) & 3);
  endfunction

  always @(negedge clk) if (rst) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, nothing queued", mem_addr, mem_data);
      end else begin
        e = wq.pop_front();
        chk("write_addr", int'(mem_addr), e.a);
        chk("write_data", int'(mem_data), e.d);
        chk("write_cycle", cyc, e.c);
      end
    end
    if (frame_done) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got pulse, expected none");
      end else chk("frame_err_at_done", int'(frame_err), dq.pop_front());
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    repeat (n) begin
      @(negedge clk); CAM_pclk = 0; clks(1);
      @(negedge clk); CAM_pclk = 1; clks(1);
    end
  endtask

  task automatic vs_set(input logic v);
    @(negedge clk);
    CAM_vsync = v;
    if (v) begin
      if (m_active) begin
        m_err = m_err | CAM_href;
        dq.push_back(int'(m_err));
      end
      m_active = 0;
      m_armed = 1;
    end else if (m_armed) begin
      m_active = 1;
      m_armed = 0;
      m_x = 0; m_y = 0; m_addr = 0; m_full = 0; m_err = 0;
    end
  endtask

  task automatic start_frame();
    vs_set(1); blank(8); vs_set(0); blank(4);
  endtask

  task automatic send_line(input int nb, input int mode, input int abort);
    int hi, lo, k;
    hi = 0; lo = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == abort) vs_set(1);
      k = i / 2 + m_y * 17;
      hi = mode ? (7 + 29 * k) & 255 : 'hF8;
      lo = mode ? (224 ^ (53 * k)) & 255 : 'h1F;
      @(negedge clk); CAM_pclk = 0; CAM_href = 1; CAM_px_data = 8'(i % 2 ? lo : hi);
      clks(1);
      @(negedge clk); CAM_pclk = 1;
      if (i % 2 == 1 && m_active) begin
        if (m_x < W && m_y < H && !m_full) begin
          wq.push_back('{m_addr, exp332(hi, lo), cyc + 5});
          m_x++;
          if (m_addr == W * H - 1) m_full = 1;
          else m_addr++;
        end else m_err = 1;
      end
      clks(1);
    end
    @(negedge clk); CAM_pclk = 0; CAM_href = 0;
    if (m_active) begin
      if (nb % 2 == 1 || (m_x != 0 && m_x != W)) m_err = 1;
      if (m_x != 0 && m_y < H) m_y++;
      m_x = 0;
    end
    clks(1);
    @(negedge clk); CAM_pclk = 1;
    clks(1);
    blank(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(3);
    chk("reset_mem_we", int'(mem_we), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    @(negedge clk); rst = 1;
    blank(4);
    start_frame();
    repeat (H) send_line(2 * W, 0, -1);
    start_frame();
    repeat (H) send_line(2 * W, 1, -1);
    start_frame();
    send_line(2 * W + 1, 1, -1);
    send_line(2 * W + 10, 1, -1);
    send_line(20, 1, -1);
    repeat (H - 3) send_line(2 * W, 1, -1);
    chk("frame_err_before_done", int'(frame_err), 1);
    start_frame();
    chk("frame_err_cleared_after_bad_lines", int'(frame_err), 0);
    repeat (H + 5) send_line(2 * W, 1, -1);
    start_frame();
    chk("frame_err_cleared_after_overflow", int'(frame_err), 0);
    repeat (5) send_line(2 * W, 1, -1);
    send_line(2 * W, 1, 10);
    blank(4);
    start_frame();
    chk("frame_err_cleared_after_abort", int'(frame_err), 0);
    repeat (4) send_line(2 * W, 1, -1);
    clks(10);
    chk("queue_drained_before_reset", wq.size(), 0);
    @(negedge clk); rst = 0;
    #1;
    chk("midreset_mem_we", int'(mem_we), 0);
    chk("midreset_mem_addr", int'(mem_addr), 0);
    chk("midreset_mem_data", int'(mem_data), 0);
    chk("midreset_frame_done", int'(frame_done), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    m_active = 0;
    m_armed = 0;
    clks(3);
    rst = 1;
    repeat (2) send_line(2 * W, 1, -1);
    start_frame();
    repeat (H) send_line(2 * W, 0, -1);
    vs_set(1);
    blank(8);
    clks(20);
    chk("write_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
